// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel clock-enable, position counters, syncs and strobes.
// Optional frame-locked motion tick is built when VGA_MOVE_TICK_EN is defined.
module vga_sync_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int CLK_DIV         = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int MOVE_DIV        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] counter_x,
  output logic [9:0] counter_y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic       line_start,
  output logic       frame_start,
  output logic       move_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Reject geometries the 10-bit counters or 8-bit frame counter cannot express.
  if (CLK_DIV < 1 || MOVE_DIV < 1 || MOVE_DIV > 255 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
    $error("vga_sync_gen: unsupported parameter combination");
  end

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [9:0]       counter_x_r;
  logic [9:0]       counter_y_r;
  logic [9:0]       nx_s;
  logic [9:0]       ny_s;
  logic             adv_s;
  logic             hs_on_s;
  logic             vs_on_s;
  logic             de_s;
  logic             line_s;
  logic             frame_s;
  logic             pix_en_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             display_en_r;
  logic             line_start_r;
  logic             frame_start_r;
  logic             move_tick_r;
  logic             move_hit_s;

  // Next divider value and next raster position; all outputs are decoded from the next position.
  always_comb begin
    adv_s     = (div_r == DIV_LAST);
    div_nxt_s = div_r + DIV_ONE;
    nx_s      = counter_x_r;
    ny_s      = counter_y_r;
    if (adv_s) begin
      div_nxt_s = DIV_ZERO;
      if (counter_x_r == X_LAST) begin
        nx_s = 10'd0;
        if (counter_y_r == Y_LAST) begin
          ny_s = 10'd0;
        end else begin
          ny_s = counter_y_r + 10'd1;
        end
      end else begin
        nx_s = counter_x_r + 10'd1;
        ny_s = counter_y_r;
      end
    end else begin
      nx_s = counter_x_r;
      ny_s = counter_y_r;
    end
  end

  // Region and strobe decode of the next position.
  always_comb begin
    hs_on_s = (nx_s >= HS_FIRST) && (nx_s <= HS_LAST);
    vs_on_s = (ny_s >= VS_FIRST) && (ny_s <= VS_LAST);
    de_s    = (nx_s < X_VIS) && (ny_s < Y_VIS);
    line_s  = adv_s && (nx_s == 10'd0);
    frame_s = line_s && (ny_s == 10'd0);
  end

  // Divider, position and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r         <= DIV_ZERO;
      counter_x_r   <= X_LAST;
      counter_y_r   <= Y_LAST;
      pix_en_r      <= 1'b0;
      hsync_r       <= SYNC_OFF;
      vsync_r       <= SYNC_OFF;
      display_en_r  <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_r         <= div_nxt_s;
      counter_x_r   <= nx_s;
      counter_y_r   <= ny_s;
      pix_en_r      <= adv_s;
      hsync_r       <= hs_on_s ? SYNC_ON : SYNC_OFF;
      vsync_r       <= vs_on_s ? SYNC_ON : SYNC_OFF;
      display_en_r  <= de_s;
      line_start_r  <= line_s;
      frame_start_r <= frame_s;
    end
  end

`ifdef VGA_MOVE_TICK_EN
  localparam logic [7:0] MOVE_LAST = 8'(MOVE_DIV - 1);

  logic [7:0] frame_cnt_r;

  // Motion tick fires on the frame_start that completes a group of MOVE_DIV frames.
  always_comb begin
    move_hit_s = frame_s && (frame_cnt_r == MOVE_LAST);
  end

  // Frame counter restarts whenever a motion tick is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if (move_hit_s) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_s) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end
`else
  assign move_hit_s = 1'b0;
`endif

  // Motion tick register, aligned with frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_tick_r <= 1'b0;
    end else begin
      move_tick_r <= move_hit_s;
    end
  end

  assign pix_en      = pix_en_r;
  assign counter_x   = counter_x_r;
  assign counter_y   = counter_y_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign display_en  = display_en_r;
  assign line_start  = line_start_r;
  assign frame_start = frame_start_r;
  assign move_tick   = move_tick_r;

endmodule
